// File: rtl/grf_writeback_sink_pkg.sv
// Shared widths, the hard-wired zero register and the write-trace record
// used by the general register file.
package grf_writeback_sink_pkg;

    localparam int unsigned GRF_DATA_W = 32;
    localparam int unsigned GRF_NREG   = 32;
    localparam int unsigned GPR_ADDR_W = $clog2(GRF_NREG);

    localparam logic [GPR_ADDR_W-1:0] ZERO_REG = GPR_ADDR_W'(0);

    typedef struct packed {
        logic [GRF_DATA_W-1:0] pc;
        logic [GPR_ADDR_W-1:0] regnum;
        logic [GRF_DATA_W-1:0] data;
    } trace_rec_t;

    // Instruction address recovered from the PC+4 carried down the pipe
    function automatic logic [GRF_DATA_W-1:0] pc_of(input logic [GRF_DATA_W-1:0] pc4);
        return pc4 - GRF_DATA_W'(4);
    endfunction

endpackage

// File: rtl/grf_writeback_sink_if.sv
// Writeback-stage bus: the W-stage result travelling into the register file.
interface grf_writeback_sink_if;

    logic                                          RegWrite_W;
    logic [grf_writeback_sink_pkg::GPR_ADDR_W-1:0] A3_W;
    logic [grf_writeback_sink_pkg::GRF_DATA_W-1:0] WD_W;
    logic [grf_writeback_sink_pkg::GRF_DATA_W-1:0] PC4_W;

    modport master (output RegWrite_W, output A3_W, output WD_W, output PC4_W);
    modport slave  (input  RegWrite_W, input  A3_W, input  WD_W, input  PC4_W);

endinterface

// File: rtl/grf_trace.sv
// Commit detection plus the registered write-trace record and commit counter.
module grf_trace
    import grf_writeback_sink_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    grf_writeback_sink_if.slave     wb,
    output logic                    commit_c,
    output logic                    valid_o,
    output trace_rec_t              rec_o,
    output logic [GRF_DATA_W-1:0]   cnt_o
);

    logic                  valid_q, valid_d;
    trace_rec_t            rec_q,   rec_d;
    logic [GRF_DATA_W-1:0] cnt_q,   cnt_d;

    // $0 writes are architecturally invisible: no commit, no trace, no count
    assign commit_c = wb.RegWrite_W && (wb.A3_W != ZERO_REG);

    always_comb begin
        valid_d = commit_c;
        rec_d   = rec_q;
        cnt_d   = cnt_q;
        if (commit_c) begin
            rec_d.pc     = pc_of(wb.PC4_W);
            rec_d.regnum = wb.A3_W;
            rec_d.data   = wb.WD_W;
            cnt_d        = cnt_q + GRF_DATA_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            rec_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rec_q   <= rec_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o = valid_q;
    assign rec_o   = rec_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/grf_writeback_sink.sv
// General register file: commits the W-stage result and serves two
// combinational decode read ports with optional same-cycle W->D bypass.
module grf_writeback_sink
    import grf_writeback_sink_pkg::*;
#(
    parameter int unsigned DATA_W = GRF_DATA_W,
    parameter int unsigned NREG   = GRF_NREG,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    grf_writeback_sink_if.slave     wb,
    input  logic [GPR_ADDR_W-1:0]   A1_D,
    input  logic [GPR_ADDR_W-1:0]   A2_D,
    output logic [DATA_W-1:0]       RD1_D,
    output logic [DATA_W-1:0]       RD2_D,
    output logic                    trace_valid,
    output logic [GRF_DATA_W-1:0]   trace_pc,
    output logic [GPR_ADDR_W-1:0]   trace_reg,
    output logic [GRF_DATA_W-1:0]   trace_data,
    output logic [GRF_DATA_W-1:0]   commit_cnt
);

    logic                  commit_c;
    trace_rec_t            rec;
    logic [GPR_ADDR_W-1:0] wa_c;
    logic [DATA_W-1:0]     wd_c;
    logic [DATA_W-1:0]     regs_q [NREG];

    assign wa_c = wb.A3_W;
    assign wd_c = DATA_W'(wb.WD_W);

    grf_trace u_trace (
        .clk      (clk),
        .reset    (reset),
        .wb       (wb),
        .commit_c (commit_c),
        .valid_o  (trace_valid),
        .rec_o    (rec),
        .cnt_o    (commit_cnt)
    );

    assign trace_pc   = rec.pc;
    assign trace_reg  = rec.regnum;
    assign trace_data = rec.data;

    // Entry 0 is never written because commit_c excludes $0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit_c) begin
            regs_q[wa_c] <= wd_c;
        end
    end

    function automatic logic [DATA_W-1:0] rd_mux(input logic [GPR_ADDR_W-1:0] ax);
        if (ax == ZERO_REG) begin
            return '0;
        end
        if (BYPASS && commit_c && (ax == wa_c)) begin
            return wd_c;
        end
        return regs_q[ax];
    endfunction

    always_comb begin
        RD1_D = rd_mux(A1_D);
        RD2_D = rd_mux(A2_D);
    end

endmodule

// File: tb/tb_grf_writeback_sink.sv
// Directed plus random bench for grf_writeback_sink: a bypassing and a
// non-bypassing instance share one writeback bus and one array model.
module tb_grf_writeback_sink;
    import grf_writeback_sink_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    grf_writeback_sink_if wb_if ();

    logic [4:0]  a1, a2;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        tv_b, tv_n;
    logic [31:0] tpc_b, tpc_n, tdata_b, tdata_n, cnt_b, cnt_n;
    logic [4:0]  treg_b, treg_n;

    grf_writeback_sink #(.BYPASS(1'b1)) dut_b (
        .clk(clk), .reset(reset), .wb(wb_if), .A1_D(a1), .A2_D(a2),
        .RD1_D(rd1_b), .RD2_D(rd2_b), .trace_valid(tv_b), .trace_pc(tpc_b),
        .trace_reg(treg_b), .trace_data(tdata_b), .commit_cnt(cnt_b));

    grf_writeback_sink #(.BYPASS(1'b0)) dut_n (
        .clk(clk), .reset(reset), .wb(wb_if), .A1_D(a1), .A2_D(a2),
        .RD1_D(rd1_n), .RD2_D(rd2_n), .trace_valid(tv_n), .trace_pc(tpc_n),
        .trace_reg(treg_n), .trace_data(tdata_n), .commit_cnt(cnt_n));

    // Reference state: architectural registers and the last trace record
    logic [31:0] mreg [32];
    logic        mvalid;
    logic [31:0] mpc, mdata, mcnt;
    logic [4:0]  mrd;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        mvalid = 1'b0; mpc = 32'd0; mrd = 5'd0; mdata = 32'd0; mcnt = 32'd0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp, input bit rw,
                                           input logic [4:0] a3, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (byp && rw && a3 != 5'd0 && a == a3) return wd;
        return mreg[a];
    endfunction

    task automatic check_trace();
        chk("trace_valid", 64'(tv_b),   64'(mvalid));
        chk("trace_pc",    64'(tpc_b),  64'(mpc));
        chk("trace_reg",   64'(treg_b), 64'(mrd));
        chk("trace_data",  64'(tdata_b),64'(mdata));
        chk("commit_cnt",  64'(cnt_b),  64'(mcnt));
        chk("trace_valid_nobyp", 64'(tv_n), 64'(mvalid));
    endtask

    // One clock: drive at negedge, check read ports, then check the edge's effect
    task automatic step(input bit rw, input logic [4:0] a3, input logic [31:0] wd,
                        input logic [31:0] pc4, input logic [4:0] ra1, input logic [4:0] ra2);
        @(negedge clk);
        wb_if.RegWrite_W = rw; wb_if.A3_W = a3; wb_if.WD_W = wd; wb_if.PC4_W = pc4;
        a1 = ra1; a2 = ra2;
        #1;
        chk("rd1_bypass",   64'(rd1_b), 64'(exp_rd(ra1, 1'b1, rw, a3, wd)));
        chk("rd2_bypass",   64'(rd2_b), 64'(exp_rd(ra2, 1'b1, rw, a3, wd)));
        chk("rd1_nobypass", 64'(rd1_n), 64'(exp_rd(ra1, 1'b0, rw, a3, wd)));
        chk("rd2_nobypass", 64'(rd2_n), 64'(exp_rd(ra2, 1'b0, rw, a3, wd)));
        @(posedge clk);
        if (rw && a3 != 5'd0) begin
            mreg[a3] = wd; mvalid = 1'b1; mpc = pc4 - 32'd4; mrd = a3; mdata = wd;
            mcnt = mcnt + 32'd1;
        end else begin
            mvalid = 1'b0;
        end
        #1;
        check_trace();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, wd, pc4;
        logic [4:0]  a3, ra1, ra2;
        bit          rw;

        // Power-on reset
        reset = 1'b0;
        wb_if.RegWrite_W = 1'b0; wb_if.A3_W = 5'd0; wb_if.WD_W = 32'd0; wb_if.PC4_W = 32'd0;
        a1 = 5'd5; a2 = 5'd31;
        model_reset();
        #2;
        chk("por_rd1", 64'(rd1_b), 64'd0);
        check_trace();
        @(negedge clk); reset = 1'b1;

        // Mid-run reset clears the array and trace at once and blocks writes
        step(1'b1, 5'd5, 32'h0000_1234, 32'h0000_1004, 5'd5, 5'd0);
        step(1'b0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd5);
        @(negedge clk); #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_rd1_bypass",   64'(rd1_b), 64'd0);
        chk("rst_rd1_nobypass", 64'(rd1_n), 64'd0);
        check_trace();
        wb_if.RegWrite_W = 1'b1; wb_if.A3_W = 5'd6; wb_if.WD_W = 32'hAAAA_5555; a1 = 5'd6;
        @(posedge clk); #1;
        chk("rst_hold_cnt", 64'(cnt_b), 64'd0);
        chk("rst_hold_rd1", 64'(rd1_n), 64'd0);
        @(negedge clk);
        wb_if.RegWrite_W = 1'b0;
        reset = 1'b1;

        // Same-cycle bypass and trace record
        step(1'b1, 5'd8, 32'hDEAD_BEEF, 32'h0000_3004, 5'd8, 5'd8);
        step(1'b0, 5'd0, 32'd0, 32'd0, 5'd8, 5'd0);

        // $0 writes are dropped
        step(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0000_4004, 5'd0, 5'd0);

        // Old value visible on the non-bypass port until the edge
        step(1'b1, 5'd3, 32'h0000_0055, 32'h0000_5004, 5'd0, 5'd3);
        step(1'b1, 5'd3, 32'h0000_0007, 32'h0000_5008, 5'd0, 5'd3);
        step(1'b0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd3);

        // Both ports hit the register being written
        step(1'b1, 5'd12, 32'h1357_9BDF, 32'h0000_6004, 5'd12, 5'd12);

        // Back-to-back writes to $9
        step(1'b1, 5'd9, 32'd1, 32'h0000_7004, 5'd9, 5'd1);
        step(1'b1, 5'd9, 32'd2, 32'h0000_7008, 5'd9, 5'd9);
        step(1'b1, 5'd9, 32'd3, 32'h0000_700C, 5'd0, 5'd9);
        step(1'b0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd9);

        // Counter wrap from all-ones
        force dut_b.u_trace.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut_b.u_trace.cnt_q;
        mcnt = 32'hFFFF_FFFF;
        #1;
        chk("cnt_preload", 64'(cnt_b), 64'(mcnt));
        step(1'b1, 5'd10, 32'h0BAD_F00D, 32'h0000_8004, 5'd10, 5'd0);
        chk("cnt_wrapped", 64'(cnt_b), 64'd0);

        // Random traffic, addresses biased to collide with the write port
        for (int i = 0; i < 300; i++) begin
            r   = $urandom;
            rw  = (r[1:0] != 2'b00);
            a3  = (r[4:2] == 3'd0) ? 5'd0 : 5'($urandom_range(0, 31));
            ra1 = r[5] ? a3 : 5'($urandom_range(0, 31));
            ra2 = r[6] ? a3 : 5'($urandom_range(0, 31));
            wd  = $urandom;
            pc4 = $urandom & 32'hFFFF_FFFC;
            step(rw, a3, wd, pc4, ra1, ra2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
